// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fifo_wr_arbiter
// Description : Two-requester round-robin write arbiter with FIFO occupancy
//               tracking. Drives the FIFO write/read strobes and keeps a
//               registered count, full/empty flags and a sticky underflow flag.
//               Optional almost_full/almost_empty flags are present only when
//               the FIFO_ALMOST_EN macro is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 4,
    parameter int FIFO_DEPTH    = 2 ** ADDRESS_WIDTH,
    parameter int ALMOST_MARGIN = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req0_valid,
    input  logic [DATA_WIDTH-1:0]  req0_data,
    output logic                   req0_ready,
    input  logic                   req1_valid,
    input  logic [DATA_WIDTH-1:0]  req1_data,
    output logic                   req1_ready,
    input  logic                   rd_req,
    output logic                   rd_ack,
    output logic [DATA_WIDTH-1:0]  fifo_write_data,
    output logic                   fifo_write_enable,
    output logic                   fifo_read_enable,
    output logic [ADDRESS_WIDTH:0] count,
    output logic                   full,
    output logic                   empty,
    output logic                   last_grant,
    output logic                   underflow_err
`ifdef FIFO_ALMOST_EN
    ,
    output logic                   almost_full,
    output logic                   almost_empty
`endif
);

    localparam logic [ADDRESS_WIDTH:0] c_depth = (ADDRESS_WIDTH + 1)'(FIFO_DEPTH);
    localparam logic [ADDRESS_WIDTH:0] c_one   = (ADDRESS_WIDTH + 1)'(1);

    logic [ADDRESS_WIDTH:0] r_count;
    logic                   r_last_grant;
    logic                   r_underflow;

    logic w_full;
    logic w_empty;
    logic w_win0;
    logic w_win1;
    logic w_ready0;
    logic w_ready1;
    logic w_wr;
    logic w_rd;

    // Flags come straight from the registered count so they are glitch-free.
    assign w_full  = (r_count == c_depth);
    assign w_empty = (r_count == '0);

    // Round-robin: a lone requester wins; on a tie the one not granted last wins.
    assign w_win0 = req0_valid & (~req1_valid | r_last_grant);
    assign w_win1 = req1_valid & (~req0_valid | ~r_last_grant);

    // Nothing is accepted while in reset, so an in-flight write is dropped.
    // A full FIFO refuses writes even if a pop happens in the same cycle.
    assign w_ready0 = w_win0 & ~w_full & ~rst;
    assign w_ready1 = w_win1 & ~w_full & ~rst;
    assign w_wr     = w_ready0 | w_ready1;
    assign w_rd     = rd_req & ~w_empty & ~rst;

    assign req0_ready        = w_ready0;
    assign req1_ready        = w_ready1;
    assign fifo_write_enable = w_wr;
    assign fifo_write_data   = w_ready0 ? req0_data :
                               w_ready1 ? req1_data : '0;
    assign rd_ack            = w_rd;
    assign fifo_read_enable  = w_rd;

    assign count         = r_count;
    assign full          = w_full;
    assign empty         = w_empty;
    assign last_grant    = r_last_grant;
    assign underflow_err = r_underflow;

    // Occupancy, grant history and sticky underflow. The external FIFO sees
    // strobes only on accepted operations and shares rst, so its pointers
    // always agree with this count, including across wrap-around.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count      <= '0;
            r_last_grant <= 1'b1;
            r_underflow  <= 1'b0;
        end else begin
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + c_one;
                2'b01:   r_count <= r_count - c_one;
                default: r_count <= r_count;
            endcase
            if (w_wr) begin
                r_last_grant <= w_ready1;
            end
            if (rd_req && w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

`ifdef FIFO_ALMOST_EN
    localparam logic [ADDRESS_WIDTH:0] c_margin = (ADDRESS_WIDTH + 1)'(ALMOST_MARGIN);

    assign almost_full  = (r_count >= (c_depth - c_margin));
    assign almost_empty = (r_count <= c_margin);
`endif

endmodule
`default_nettype wire

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, giving the payload width in bits.
REQ-002 The block SHALL have parameter ADDRESS_WIDTH, default 4, giving the FIFO pointer width.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 2**ADDRESS_WIDTH, giving the FIFO capacity in entries.
REQ-004 The block SHALL have parameter ALMOST_MARGIN, default 2, giving the almost-flag threshold in entries.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 The block SHALL have ports req0_valid and req1_valid, input, 1 bit each: the requester has a word to write.
REQ-008 The block SHALL have ports req0_data and req1_data, input, DATA_WIDTH each: the requester write payloads.
REQ-009 The block SHALL have ports req0_ready and req1_ready, output, 1 bit each: the write is accepted this cycle.
REQ-010 The block SHALL have port rd_req, input, 1 bit: the consumer requests a pop.
REQ-011 The block SHALL have port rd_ack, output, 1 bit: the pop is accepted this cycle.
REQ-012 The block SHALL have port fifo_write_data, output, DATA_WIDTH: the data to the FIFO write port.
REQ-013 The block SHALL have ports fifo_write_enable and fifo_read_enable, output, 1 bit each: the FIFO strobes.
REQ-014 The block SHALL have port count, output, ADDRESS_WIDTH+1: the current occupancy.
REQ-015 The block SHALL have ports full and empty, output, 1 bit each: the occupancy flags.
REQ-016 The block SHALL have port last_grant, output, 1 bit: the index of the requester most recently accepted.
REQ-017 The block SHALL have port underflow_err, output, 1 bit: a sticky flag recording a pop request made while empty.
REQ-018 The block SHALL have ports almost_full and almost_empty, output, 1 bit each, present only under FIFO_ALMOST_EN.

Function
REQ-019 The write grant SHALL be round-robin: a single valid requester wins; when both are valid, the requester not equal to last_grant wins.
REQ-020 reqN_ready SHALL be combinational: high only when requester N wins the arbitration AND full=0; at most one ready is high per cycle.
REQ-021 fifo_write_enable SHALL equal (req0_ready | req1_ready), and fifo_write_data SHALL be the winner's data; fifo_write_data SHALL be 0 when no write is accepted.
REQ-022 last_grant SHALL update to the accepted index on the clock edge after acceptance, and SHALL be held otherwise.
REQ-023 rd_ack and fifo_read_enable SHALL be combinational and equal to (rd_req & ~empty).
REQ-024 When full=1, all writes SHALL be refused even if a pop occurs in the same cycle; when empty=1, all pops SHALL be refused even if a write occurs in the same cycle.
REQ-025 count SHALL be registered with the following update: +1 on a write only, -1 on a pop only, unchanged on both or neither; it SHALL never exceed FIFO_DEPTH and never go below 0.
REQ-026 full SHALL be (count==FIFO_DEPTH) and empty SHALL be (count==0), both decoded from the registered count.
REQ-027 underflow_err SHALL set on the clock edge after any cycle with rd_req=1 and empty=1, and SHALL clear only on rst.
REQ-028 The occupancy seen by the FIFO's internal pointers SHALL stay consistent with count across pointer wrap-around, because the FIFO is strobed only on accepted operations.

Reset
REQ-029 With rst=1 at a clock edge, the block SHALL reset count=0, last_grant=1 (so req0 wins the first tie), and underflow_err=0.
REQ-030 The reset-driven outputs SHALL be: empty=1, full=0, all readies 0, rd_ack 0, and fifo strobes 0 while rst=1.
REQ-031 rst SHALL also reset the FIFO pointers, so that a reset in mid-operation discards all contents consistently.
REQ-032 A reset asserted in mid-transfer SHALL discard the in-flight write, and the block SHALL NOT assert readies during the reset cycle.

Configuration
REQ-033 With FIFO_ALMOST_EN defined, the block SHALL provide almost_full=(count>=FIFO_DEPTH-ALMOST_MARGIN) and almost_empty=(count<=ALMOST_MARGIN), both decoded from the registered count.
REQ-034 Without FIFO_ALMOST_EN, the almost_full and almost_empty ports and their logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-035 The bench SHALL hold both valids high for 4 cycles from reset, with data 0xA0/0xB0, and check that grants alternate req0, req1, req0, req1 and that count reaches 4.
REQ-036 The bench SHALL fill to 16 with req0 only, then hold req0_valid=1 and req1_valid=1, and check full=1, both readies 0, and count held at 16.
REQ-037 With count=16, the bench SHALL apply rd_req=1 plus req0_valid=1, and check rd_ack=1, req0_ready=0, and count 15 on the next cycle.
REQ-038 With count=3, the bench SHALL apply a write and a pop together, and check that count stays 3 and that both strobes are high.
REQ-039 From empty, the bench SHALL apply rd_req=1 for 1 cycle, and check rd_ack=0 and underflow_err=1 sticky until rst.
REQ-040 With FIFO_ALMOST_EN and ALMOST_MARGIN=2, the bench SHALL check almost_full at count 14 and almost_empty at count 2, and SHALL apply rst at count 7 to check count=0 and empty=1 on the next edge.
